sram_responder: RTL

Clocked SRAM-device-side responder for the 16-bit asynchronous-SRAM bus that the on-chip memory controller drives through its tristate buffer. It owns a small byte-lane-writable word array and samples the active-low chip controls and address on every rising edge. It performs writes and drives read data back onto the shared inout bus under a three-state turnaround machine. It serves as the synthesizable memory target for simulation and on-chip loopback testing of the controller path.

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_if.sv | 21 ++
 rtl/sram_array.sv | 44 ++++
 rtl/sram_responder.sv | 81 ++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types for the SRAM-device-side responder: turnaround FSM states and lane count.
package sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_DRIVE,
    S_TURN
  } sram_state_t;

  localparam int LANES = 2;

endpackage

// File: rtl/sram_if.sv
// Active-low chip controls and word address that the memory controller presents to the SRAM.
interface sram_if #(
  parameter int AW = 10
);

  logic          CE_N;
  logic          OE_N;
  logic          WE_N;
  logic          UB_N;
  logic          LB_N;
  logic [AW-1:0] ADDR;

  modport master (
    output CE_N, OE_N, WE_N, UB_N, LB_N, ADDR
  );

  modport slave (
    input CE_N, OE_N, WE_N, UB_N, LB_N, ADDR
  );

endinterface

// File: rtl/sram_array.sv
// Byte-lane-writable word array with a registered synchronous read port (block-RAM style).
module sram_array
  import sram_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [LANES-1:0] i_laneMask,
  input  logic [AW-1:0]    i_addr,
  input  logic [N-1:0]     i_wdata,
  input  logic             i_re,
  output logic [N-1:0]     o_rdata
);

  localparam int LW = N / LANES;

  logic [N-1:0] r_mem [0:(1<<AW)-1];
  logic [N-1:0] r_rdata;

  // Array contents are deliberately left unreset so the storage maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_laneMask[i]) begin
          r_mem[i_addr][i*LW +: LW] <= i_wdata[i*LW +: LW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_responder.sv
// SRAM target on the shared 16-bit bus: decodes sampled controls, writes the array and
// drives read data back under a drive/turnaround FSM, flagging writes that collide with it.
module sram_responder
  import sram_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  sram_if.slave        bus,
  inout  wire  [N-1:0] Data,
  output logic         drive_en,
  output logic         contention_err
);

  localparam int LW = N / LANES;

  sram_state_t      r_state;
  sram_state_t      w_nextState;
  logic [LANES-1:0] r_rdLanes;
  logic             r_contention;
  logic             w_wr;
  logic             w_rd;
  logic [LANES-1:0] w_laneMask;
  logic [N-1:0]     w_rdBuf;

  // Write wins over read, so OE_N is a don't-care whenever WE_N is low.
  assign w_wr       = !bus.CE_N && !bus.WE_N;
  assign w_rd       = !bus.CE_N && !bus.OE_N && bus.WE_N;
  assign w_laneMask = {!bus.UB_N, !bus.LB_N};

  sram_array #(
    .N  (N),
    .AW (AW)
  ) u_array (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .i_we       (w_wr),
    .i_laneMask (w_laneMask),
    .i_addr     (bus.ADDR),
    .i_wdata    (Data),
    .i_re       (w_rd),
    .o_rdata    (w_rdBuf)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_rdLanes    <= '0;
      r_contention <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_rd) begin
        r_rdLanes <= w_laneMask;
      end
      if (w_wr && (r_state != S_IDLE)) begin
        r_contention <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:     w_nextState = w_rd ? S_RD_DRIVE : S_IDLE;
      S_RD_DRIVE: w_nextState = w_rd ? S_RD_DRIVE : S_TURN;
      S_TURN:     w_nextState = w_rd ? S_RD_DRIVE : S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  assign drive_en       = (r_state == S_RD_DRIVE);
  assign contention_err = r_contention;

  // Lane enables depend only on registered state, never on live bus inputs.
  for (genvar g = 0; g < LANES; g++) begin : gLane
    assign Data[g*LW +: LW] = (drive_en && r_rdLanes[g]) ? w_rdBuf[g*LW +: LW] : {LW{1'bz}};
  end

endmodule
